sobel_edge: RTL and testbench

- Sobel gradient stage placed directly downstream of the 3x3 Gaussian blur in the edge-detection chain.
- Consumes the blurred grayscale pixel stream with its vsync/hsync/de timing.
- Forms a 3x3 window from two line buffers, computes |Gx|+|Gy|, and forces frame-border pixels to zero.
- Emits either a clamped gradient magnitude or a thresholded binary edge map, time-aligned with delayed sync signals.

---
 rtl/sobel_edge.sv | 147 ++++++++++++++
 tb/tb_sobel_edge.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sobel_edge.sv
// Sobel |Gx|+|Gy| edge stage, 3-clock latency, zeroed frame border.
// Define SOBEL_THRESH_OUT_EN for a thresholded binary edge map.
module sobel_edge #(
    parameter int WIDTH = 8,
    parameter int H_RES = 80,
    parameter int V_RES = 60
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_vsync,
    input  logic             i_hsync,
    input  logic             i_de,
    input  logic [WIDTH-1:0] i_data,
    input  logic [WIDTH-1:0] i_thresh,
    output logic             o_vsync,
    output logic             o_hsync,
    output logic             o_de,
    output logic [WIDTH-1:0] o_data
);
    localparam int CW = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int RW = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam int GW = WIDTH + 3;
    localparam logic [CW-1:0] COL_LAST = CW'(H_RES - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(V_RES - 1);

    logic [WIDTH-1:0] lb0 [H_RES];
    logic [WIDTH-1:0] lb1 [H_RES];
    logic [WIDTH-1:0] win [3][3];

    logic          vs_d;
    logic          frame_start;
    logic [CW-1:0] col, col_cur;
    logic [RW-1:0] row, row_cur;
    logic          border1, border2;

    logic signed [GW-1:0] gx, gy, gx_n, gy_n;
    logic [GW-1:0]        ax, ay, mag;
    logic [WIDTH-1:0]     result;
    logic [2:0]           vs_sr, hs_sr, de_sr;

    // A pixel arriving with the vsync edge is already col 0, row 0.
    assign frame_start = i_vsync & ~vs_d;
    assign col_cur     = frame_start ? '0 : col;
    assign row_cur     = frame_start ? '0 : row;

    always_ff @(posedge clk) begin
        if (i_de) begin
            lb0[col_cur] <= i_data;
            lb1[col_cur] <= lb0[col_cur];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vs_d    <= 1'b0;
            col     <= '0;
            row     <= '0;
            border1 <= 1'b0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win[r][c] <= '0;
        end else begin
            vs_d <= i_vsync;
            if (i_de) begin
                for (int r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                end
                win[0][2] <= lb1[col_cur];
                win[1][2] <= lb0[col_cur];
                win[2][2] <= i_data;
                border1   <= (row_cur < RW'(2)) || (col_cur < CW'(2));
                if (col_cur == COL_LAST) begin
                    col <= '0;
                    row <= (row_cur == ROW_LAST) ? row_cur : row_cur + RW'(1);
                end else begin
                    col <= col_cur + CW'(1);
                    row <= row_cur;
                end
            end else if (frame_start) begin
                col <= '0;
                row <= '0;
            end
        end
    end

    always_comb begin
        gx_n = GW'(win[0][2]) + (GW'(win[1][2]) << 1) + GW'(win[2][2])
             - GW'(win[0][0]) - (GW'(win[1][0]) << 1) - GW'(win[2][0]);
        gy_n = GW'(win[2][0]) + (GW'(win[2][1]) << 1) + GW'(win[2][2])
             - GW'(win[0][0]) - (GW'(win[0][1]) << 1) - GW'(win[0][2]);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gx      <= '0;
            gy      <= '0;
            border2 <= 1'b0;
        end else begin
            gx      <= gx_n;
            gy      <= gy_n;
            border2 <= border1;
        end
    end

    always_comb begin
        ax  = gx[GW-1] ? GW'(-gx) : GW'(gx);
        ay  = gy[GW-1] ? GW'(-gy) : GW'(gy);
        mag = ax + ay;
    end

`ifdef SOBEL_THRESH_OUT_EN
    always_comb begin
        result = '0;
        if (!border2 && (mag > GW'(i_thresh)))
            result = '1;
    end
`else
    logic unused_thresh;
    assign unused_thresh = ^i_thresh;

    always_comb begin
        result = '0;
        if (!border2)
            result = (|mag[GW-1:WIDTH]) ? '1 : mag[WIDTH-1:0];
    end
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vs_sr  <= '0;
            hs_sr  <= '0;
            de_sr  <= '0;
            o_data <= '0;
        end else begin
            vs_sr  <= {vs_sr[1:0], i_vsync};
            hs_sr  <= {hs_sr[1:0], i_hsync};
            de_sr  <= {de_sr[1:0], i_de};
            o_data <= result;
        end
    end

    assign o_vsync = vs_sr[2];
    assign o_hsync = hs_sr[2];
    assign o_de    = de_sr[2];

endmodule

// File: tb/tb_sobel_edge.sv
// Directed bench for sobel_edge on an 8x6 frame: flat, steps, ramp,
// de gaps and mid-frame reset, with 3-clock sync/data alignment.
module tb_sobel_edge;
    localparam int W  = 8;
    localparam int HR = 8;
    localparam int VR = 6;

    logic         clk;
    logic         rstn;
    logic         i_vsync, i_hsync, i_de;
    logic [W-1:0] i_data, i_thresh;
    logic         o_vsync, o_hsync, o_de;
    logic [W-1:0] o_data;

    int errors = 0;
    int checks = 0;

    logic         ev_vs [3];
    logic         ev_hs [3];
    logic         ev_de [3];
    logic [W-1:0] ev_d  [3];

    sobel_edge #(.WIDTH(W), .H_RES(HR), .V_RES(VR)) dut (
        .clk(clk), .rstn(rstn),
        .i_vsync(i_vsync), .i_hsync(i_hsync), .i_de(i_de),
        .i_data(i_data), .i_thresh(i_thresh),
        .o_vsync(o_vsync), .o_hsync(o_hsync), .o_de(o_de),
        .o_data(o_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kinds: 0 flat 100, 1 vertical step, 2 horizontal step, 3 ramp 10*col
    function automatic int pix(int k, int r, int c);
        case (k)
            0:       return 100;
            1:       return (c >= 4) ? 255 : 0;
            2:       return (r >= 3) ? 255 : 0;
            default: return 10 * c;
        endcase
    endfunction

    // Hand-derived |Gx|+|Gy| for the window ending at accepted (r,c).
    function automatic int mag(int k, int r, int c);
        case (k)
            0:       return 0;
            1:       return (c == 4 || c == 5) ? 1020 : 0;
            2:       return (r == 3 || r == 4) ? 1020 : 0;
            default: return 80;
        endcase
    endfunction

    function automatic logic [W-1:0] expect_px(int k, int r, int c, int thr);
        int m;
        if (r < 2 || c < 2) return '0;
        m = mag(k, r, c);
`ifdef SOBEL_THRESH_OUT_EN
        return (m > thr) ? 8'd255 : 8'd0;
`else
        return (m > 255) ? 8'd255 : W'(m);
`endif
    endfunction

    task automatic clear_hist();
        for (int i = 0; i < 3; i++) begin
            ev_vs[i] = 1'b0;
            ev_hs[i] = 1'b0;
            ev_de[i] = 1'b0;
            ev_d[i]  = '0;
        end
    endtask

    task automatic step(input logic vs, input logic hs, input logic de,
                        input logic [W-1:0] d, input logic [W-1:0] e);
        for (int i = 2; i > 0; i--) begin
            ev_vs[i] = ev_vs[i-1];
            ev_hs[i] = ev_hs[i-1];
            ev_de[i] = ev_de[i-1];
            ev_d[i]  = ev_d[i-1];
        end
        ev_vs[0] = vs;
        ev_hs[0] = hs;
        ev_de[0] = de;
        ev_d[0]  = e;
        i_vsync  = vs;
        i_hsync  = hs;
        i_de     = de;
        i_data   = d;
        @(posedge clk);
        #1;
        checks++;
        assert (o_vsync === ev_vs[2]) else begin
            errors++;
            $error("FAIL vsync got %0b exp %0b", o_vsync, ev_vs[2]);
        end
        checks++;
        assert (o_hsync === ev_hs[2]) else begin
            errors++;
            $error("FAIL hsync got %0b exp %0b", o_hsync, ev_hs[2]);
        end
        checks++;
        assert (o_de === ev_de[2]) else begin
            errors++;
            $error("FAIL de got %0b exp %0b", o_de, ev_de[2]);
        end
        if (ev_de[2]) begin
            checks++;
            assert (o_data === ev_d[2]) else begin
                errors++;
                $error("FAIL data got %0d exp %0d", o_data, ev_d[2]);
            end
        end
    endtask

    // Returns early (no flush) when reaching pixel (sr,sc).
    task automatic run_frame(input int k, input int gap, input int thr,
                             input int sr, input int sc);
        i_thresh = W'(thr);
        step(1'b1, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b0, 1'b0, '0, '0);
        for (int r = 0; r < VR; r++) begin
            step(1'b0, 1'b1, 1'b0, '0, '0);
            for (int c = 0; c < HR; c++) begin
                if (r == sr && c == sc) return;
                step(1'b0, 1'b0, 1'b1, W'(pix(k, r, c)),
                     expect_px(k, r, c, thr));
                for (int g = 0; g < gap; g++)
                    step(1'b0, 1'b0, 1'b0, 8'hA5, '0);
            end
            step(1'b0, 1'b0, 1'b0, '0, '0);
            step(1'b0, 1'b0, 1'b0, '0, '0);
        end
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic check_zero(input string tag);
        checks++;
        assert ({o_vsync, o_hsync, o_de, o_data} === 11'd0) else begin
            errors++;
            $error("FAIL %s got %b exp 0", tag,
                   {o_vsync, o_hsync, o_de, o_data});
        end
    endtask

    initial begin
        clear_hist();
        rstn     = 1'b0;
        i_vsync  = 1'b0;
        i_hsync  = 1'b0;
        i_de     = 1'b0;
        i_data   = '0;
        i_thresh = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_state");
        rstn = 1'b1;

        run_frame(0, 0, 0, -1, -1);
        run_frame(1, 0, 0, -1, -1);
        run_frame(2, 0, 0, -1, -1);
        run_frame(3, 0, 79, -1, -1);
        run_frame(3, 0, 80, -1, -1);
        run_frame(1, 3, 0, -1, -1);

        // Mid-frame reset with a busy pipeline
        run_frame(2, 0, 0, 3, 5);
        i_de   = 1'b1;
        i_data = 8'd255;
        #2;
        rstn = 1'b0;
        #1;
        check_zero("reset_async");
        i_de = 1'b0;
        @(posedge clk);
        #1;
        check_zero("reset_hold");
        rstn = 1'b1;
        clear_hist();
        run_frame(0, 0, 0, -1, -1);
        run_frame(1, 0, 0, -1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
